// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with valid/ready load handshake, count enable,
// abort, optional auto-reload and a one-cycle registered terminal-count pulse.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] reload_reg, reload_nx;
    logic             reload_en, reload_en_nx;
    logic             done_nx;
    logic             accept;

    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN);
    assign accept     = load_valid & load_ready;

    // State and datapath registers; active-low reset overrides every input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            reload_reg <= '0;
            reload_en  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            reload_reg <= reload_nx;
            reload_en  <= reload_en_nx;
            done       <= done_nx;
        end
    end

    // Next-state and next-count logic; abort outranks decrement and terminal count.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        reload_nx    = reload_reg;
        reload_en_nx = reload_en;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (load_val != '0) begin
                        cnt_nx       = load_val;
                        reload_nx    = load_val;
                        reload_en_nx = auto_reload;
                        state_nx     = RUN;
                    end else begin
                        // A zero load expires immediately: pulse done, stay idle.
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (en) begin
                    if (cnt == ONE) begin
                        done_nx = 1'b1;
                        if (reload_en) begin
                            cnt_nx = reload_reg;
                        end else begin
                            cnt_nx   = '0;
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: a behavioural reference model is
// updated on every rising edge and compared to the DUT on every falling edge,
// alongside hand-computed literal checks of each scenario.
module tb_down_counter_timer;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .en         (en),
        .abort      (abort),
        .cnt        (cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: remaining count, running flag, period and reload mode.
    int  m_cnt    = 0;
    int  m_period = 0;
    bit  m_run    = 0;
    bit  m_auto   = 0;
    bit  m_done   = 0;
    bit  m_valid  = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt = 0; m_period = 0; m_run = 0; m_auto = 0; m_done = 0;
            m_valid = 1;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (load_valid) begin
                    if (load_val == 0) begin
                        m_done = 1;
                    end else begin
                        m_cnt    = int'(load_val);
                        m_period = int'(load_val);
                        m_auto   = auto_reload;
                        m_run    = 1;
                    end
                end
            end else if (abort) begin
                m_cnt = 0;
                m_run = 0;
            end else if (en) begin
                if (m_cnt == 1) begin
                    m_done = 1;
                    if (m_auto) m_cnt = m_period;
                    else begin
                        m_cnt = 0;
                        m_run = 0;
                    end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_cnt",   int'(cnt),        m_cnt);
            chk("model_busy",  int'(busy),       int'(m_run));
            chk("model_ready", int'(load_ready), int'(!m_run));
            chk("model_done",  int'(done),       int'(m_done));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int c, input int b, input int d);
        chk({name, "_cnt"},  int'(cnt),  c);
        chk({name, "_busy"}, int'(busy), b);
        chk({name, "_done"}, int'(done), d);
    endtask

    initial begin
        int exp4[7];
        rst = 1'b0; load_valid = 1'b1; load_val = 4'd5;
        auto_reload = 1'b0; en = 1'b0; abort = 1'b0;

        // 1: reset for two cycles with a load request present.
        step(); step();
        lit("t1_reset", 0, 0, 0);
        chk("t1_ready", int'(load_ready), 1);

        // 2: load 5, no reload, enabled.
        rst = 1'b1; load_valid = 1'b1; load_val = 4'd5; en = 1'b1;
        step();
        load_valid = 1'b0;
        lit("t2_accept", 5, 1, 0);
        chk("t2_ready_run", int'(load_ready), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            lit("t2_count", 5 - i, (i < 5) ? 1 : 0, (i == 5) ? 1 : 0);
        end
        chk("t2_ready_done", int'(load_ready), 1);
        step();
        lit("t2_after", 0, 0, 0);

        // 3: load 3, pause two cycles at 2.
        load_valid = 1'b1; load_val = 4'd3; en = 1'b1;
        step();
        load_valid = 1'b0;
        lit("t3_accept", 3, 1, 0);
        step(); lit("t3_c1", 2, 1, 0);
        en = 1'b0;
        step(); lit("t3_hold1", 2, 1, 0);
        step(); lit("t3_hold2", 2, 1, 0);
        en = 1'b1;
        step(); lit("t3_c4", 1, 1, 0);
        step(); lit("t3_done", 0, 0, 1);

        // 4: load 4 with auto-reload, then abort at cnt 1.
        load_valid = 1'b1; load_val = 4'd4; auto_reload = 1'b1;
        step();
        load_valid = 1'b0; auto_reload = 1'b0;
        lit("t4_accept", 4, 1, 0);
        exp4 = '{3, 2, 1, 4, 3, 2, 1};
        for (int i = 0; i < 7; i++) begin
            step();
            lit("t4_seq", exp4[i], 1, (i == 3) ? 1 : 0);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        lit("t4_abort", 0, 0, 0);
        chk("t4_ready", int'(load_ready), 1);
        // abort and en in IDLE are ignored
        abort = 1'b1;
        step();
        abort = 1'b0;
        lit("t4_idle_abort", 0, 0, 0);

        // 5: zero load, then full-range load with ignored reloads in RUN.
        load_valid = 1'b1; load_val = 4'd0;
        step();
        load_valid = 1'b0;
        lit("t5_zero", 0, 0, 1);
        step();
        lit("t5_zero_after", 0, 0, 0);
        load_valid = 1'b1; load_val = 4'd15;
        step();
        load_valid = 1'b0;
        lit("t5_accept15", 15, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            load_valid = (i % 2 == 1 && i < 14) ? 1'b1 : 1'b0;
            load_val   = 4'd3;
            step();
            lit("t5_count", 15 - i, (i < 15) ? 1 : 0, (i == 15) ? 1 : 0);
        end
        // load accepted in the same cycle done is shown
        load_valid = 1'b1; load_val = 4'd2;
        step();
        load_valid = 1'b0;
        lit("t5_reload_imm", 2, 1, 0);
        step(); lit("t5_r1", 1, 1, 0);
        step(); lit("t5_r2", 0, 0, 1);

        // 6: reset in the middle of an auto-reload run at cnt 7.
        load_valid = 1'b1; load_val = 4'd9; auto_reload = 1'b1;
        step();
        load_valid = 1'b0; auto_reload = 1'b0;
        step(); step();
        lit("t6_pre", 7, 1, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        lit("t6_reset", 0, 0, 0);
        chk("t6_ready", int'(load_ready), 1);
        step();
        lit("t6_after", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
